// File: rtl/ro_puf_engine.sv
`default_nettype none
// ============================================================================
// Module   : ro_puf_engine
// Function : Ring-oscillator PUF. Races the rising edges of oscillator pairs
//            and turns each pair into one response bit.
// Revision : 1.0
// ============================================================================
module ro_puf_engine #(
    parameter int NUM_RO     = 16,
    parameter int RESP_BITS  = 8,
    parameter int CNT_W      = 16,
    parameter int WINDOW     = 1024,
    parameter int SETTLE_CYC = 8,
    parameter int CFG_W      = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [$clog2(NUM_RO)-1:0] challenge,
    input  logic [CFG_W-1:0]          cfg,
    input  logic [NUM_RO-1:0]         ro_in,
    output logic [NUM_RO-1:0]         ro_enable,
    output logic [CFG_W-1:0]          ro_cfg,
    output logic [RESP_BITS-1:0]      response,
    output logic                      valid,
    output logic                      busy,
    output logic [RESP_BITS-1:0]      tie
);

    localparam int IDX_W   = $clog2(NUM_RO);
    localparam int PAIR_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int SUM_W   = IDX_W + PAIR_W + 2;
    localparam int TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]  WINDOW_LAST = TMR_W'(WINDOW - 1);
    localparam logic [PAIR_W-1:0] PAIR_LAST   = PAIR_W'(RESP_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_RO - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        COUNT   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      chal_q, chal_d;
    logic [CFG_W-1:0]      cfg_q, cfg_d;
    logic [PAIR_W-1:0]     pair_q, pair_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]      cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]      cnt_b_q, cnt_b_d;
    logic [RESP_BITS-1:0]  shadow_q, shadow_d;
    logic [RESP_BITS-1:0]  tie_sh_q, tie_sh_d;
    logic [RESP_BITS-1:0]  response_q, response_d;
    logic [RESP_BITS-1:0]  tie_q, tie_d;
    logic                  valid_q, valid_d;
    logic [NUM_RO-1:0]     sync1_q, sync1_d;
    logic [NUM_RO-1:0]     sync2_q, sync2_d;
    logic [NUM_RO-1:0]     prev_q, prev_d;

    logic [NUM_RO-1:0]     w_rise;
    logic [SUM_W-1:0]      w_pair_sum;
    logic [IDX_W-1:0]      w_a_idx;
    logic [IDX_W-1:0]      w_b_idx;

    // ro_in is asynchronous: two-flop synchronizer, then a one-flop edge detector
    always_comb begin
        sync1_d = ro_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    assign w_rise = sync2_q & ~prev_q;

    always_comb begin
        w_pair_sum = SUM_W'(chal_q) + (SUM_W'(pair_q) << 1);
        w_a_idx    = IDX_W'(w_pair_sum % SUM_W'(NUM_RO));
        w_b_idx    = (w_a_idx == IDX_LAST) ? '0 : w_a_idx + IDX_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        chal_d     = chal_q;
        cfg_d      = cfg_q;
        pair_d     = pair_q;
        timer_d    = timer_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        shadow_d   = shadow_q;
        tie_sh_d   = tie_sh_q;
        response_d = response_q;
        tie_d      = tie_q;
        valid_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    chal_d   = challenge;
                    cfg_d    = cfg;
                    pair_d   = '0;
                    timer_d  = '0;
                    shadow_d = '0;
                    tie_sh_d = '0;
                end
            end
            SETTLE: begin
                cnt_a_d = '0;
                cnt_b_d = '0;
                if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    state_d = COUNT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            COUNT: begin
                if (w_rise[w_a_idx] && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CNT_W'(1);
                if (w_rise[w_b_idx] && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CNT_W'(1);
                if (timer_q == WINDOW_LAST) begin
                    timer_d = '0;
                    state_d = COMPARE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            COMPARE: begin
                shadow_d[pair_q] = (cnt_a_q > cnt_b_q);
                tie_sh_d[pair_q] = (cnt_a_q == cnt_b_q);
                if (pair_q == PAIR_LAST) begin
                    // Publish on the way into DONE so response/tie are valid alongside the pulse
                    state_d    = DONE;
                    response_d = shadow_d;
                    tie_d      = tie_sh_d;
                    valid_d    = 1'b1;
                end else begin
                    pair_d  = pair_q + PAIR_W'(1);
                    state_d = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            chal_q     <= '0;
            cfg_q      <= '0;
            pair_q     <= '0;
            timer_q    <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            shadow_q   <= '0;
            tie_sh_q   <= '0;
            response_q <= '0;
            tie_q      <= '0;
            valid_q    <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
        end else begin
            state_q    <= state_d;
            chal_q     <= chal_d;
            cfg_q      <= cfg_d;
            pair_q     <= pair_d;
            timer_q    <= timer_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            shadow_q   <= shadow_d;
            tie_sh_q   <= tie_sh_d;
            response_q <= response_d;
            tie_q      <= tie_d;
            valid_q    <= valid_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
        end
    end

    always_comb begin
        ro_enable = '0;
        if ((state_q == SETTLE) || (state_q == COUNT) || (state_q == COMPARE)) begin
            ro_enable[w_a_idx] = 1'b1;
            ro_enable[w_b_idx] = 1'b1;
        end
    end

    assign busy     = (state_q != IDLE);
    assign valid    = valid_q;
    assign response = response_q;
    assign tie      = tie_q;
    assign ro_cfg   = cfg_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ro_puf_engine
// Function : Directed, table-driven bench for ro_puf_engine.
// Revision : 1.0
// ============================================================================
module tb_ro_puf_engine;

    localparam int NR       = 4;
    localparam int RB       = 2;
    localparam int WIN      = 64;
    localparam int SET      = 4;
    localparam int CW       = 6;
    localparam int PAIR_CYC = SET + WIN + 1;
    localparam int LAT      = RB * PAIR_CYC + 1;
    localparam int NVEC     = 6;

    typedef struct packed {
        logic [NR-1:0][7:0] per;
        logic [1:0]         chal;
        logic [CW-1:0]      cfg;
        logic [RB-1:0]      exp_resp;
        logic [RB-1:0]      exp_tie;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          start_s = 1'b0;
    logic [1:0]    challenge = '0;
    logic [CW-1:0] cfg = '0;
    logic [NR-1:0] ro_in = '0;
    logic [NR-1:0] ro_in_s = '0;

    logic [NR-1:0] ro_enable, ro_enable_s;
    logic [CW-1:0] ro_cfg, ro_cfg_s;
    logic [RB-1:0] response, response_s, tie, tie_s;
    logic          valid, valid_s, busy, busy_s;

    int per_m[NR] = '{4, 8, 8, 4};
    int per_s[NR] = '{2, 2, 2, 8};
    int tcnt = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [RB-1:0] last_resp = '0;
    logic [RB-1:0] last_tie = '0;
    logic [CW-1:0] last_cfg = '0;
    vec_t vecs[NVEC];

    ro_puf_engine #(
        .NUM_RO(NR), .RESP_BITS(RB), .CNT_W(16), .WINDOW(WIN), .SETTLE_CYC(SET), .CFG_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .challenge(challenge), .cfg(cfg),
        .ro_in(ro_in), .ro_enable(ro_enable), .ro_cfg(ro_cfg), .response(response),
        .valid(valid), .busy(busy), .tie(tie)
    );

    ro_puf_engine #(
        .NUM_RO(NR), .RESP_BITS(RB), .CNT_W(4), .WINDOW(WIN), .SETTLE_CYC(SET), .CFG_W(CW)
    ) dut_sat (
        .clk(clk), .reset(reset), .start(start_s), .challenge(challenge), .cfg(cfg),
        .ro_in(ro_in_s), .ro_enable(ro_enable_s), .ro_cfg(ro_cfg_s), .response(response_s),
        .valid(valid_s), .busy(busy_s), .tie(tie_s)
    );

    always #5 clk = ~clk;

    // Oscillators: square waves with even periods in clk cycles, changing on the falling edge
    always @(negedge clk) begin
        tcnt <= tcnt + 1;
        for (int i = 0; i < NR; i++) begin
            ro_in[i]   <= ((tcnt % per_m[i]) < (per_m[i] / 2));
            ro_in_s[i] <= ((tcnt % per_s[i]) < (per_s[i] / 2));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] pair_mask(input int chal, input int pair);
        logic [NR-1:0] m;
        m = '0;
        m[(chal + 2 * pair) % NR]     = 1'b1;
        m[(chal + 2 * pair + 1) % NR] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] snap_m();
        return {valid, busy, ro_enable, response, tie, ro_cfg};
    endfunction

    function automatic logic [15:0] snap_s();
        return {valid_s, busy_s, ro_enable_s, response_s, tie_s, ro_cfg_s};
    endfunction

    function automatic vec_t mkvec(input int p0, input int p1, input int p2, input int p3,
                                   input logic [1:0] chal, input logic [CW-1:0] c,
                                   input logic [RB-1:0] r, input logic [RB-1:0] t);
        vec_t v;
        v.per[0]   = 8'(p0);
        v.per[1]   = 8'(p1);
        v.per[2]   = 8'(p2);
        v.per[3]   = 8'(p3);
        v.chal     = chal;
        v.cfg      = c;
        v.exp_resp = r;
        v.exp_tie  = t;
        return v;
    endfunction

    // One full measurement on the main DUT, checking every output on every cycle.
    // challenge/cfg are scrambled right after acceptance; repulse adds ignored starts.
    task automatic run_meas(input string name, input int chal, input logic [CW-1:0] cf,
                            input logic [RB-1:0] er, input logic [RB-1:0] et, input bit repulse);
        logic [15:0] e;
        @(negedge clk);
        e = {1'b0, 1'b0, 4'b0000, last_resp, last_tie, last_cfg};
        chk({name, " idle"}, 32'(snap_m()), 32'(e));
        challenge = 2'(chal);
        cfg       = cf;
        start     = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k < LAT) e = {1'b0, 1'b1, pair_mask(chal, (k - 1) / PAIR_CYC), last_resp, last_tie, cf};
            else         e = {1'b1, 1'b1, 4'b0000, er, et, cf};
            chk($sformatf("%s cyc%0d", name, k), 32'(snap_m()), 32'(e));
            start = 1'b0;
            if (k == 1) begin
                challenge = 2'(chal + 1);
                cfg       = ~cf;
            end
            if (repulse && (k == 40 || k == 100)) begin
                start     = 1'b1;
                challenge = 2'(chal + 2);
            end
        end
        last_resp = er;
        last_tie  = et;
        last_cfg  = cf;
    endtask

    initial begin
        logic [15:0] e;
        int vk;

        vecs[0] = mkvec(4, 8, 8, 4,  2'd0, 6'h2A, 2'b01, 2'b00);
        // Pairs (3,0) and (1,2) each race equal-period oscillators, so both bits tie
        vecs[1] = mkvec(4, 8, 8, 4,  2'd3, 6'h15, 2'b00, 2'b11);
        vecs[2] = mkvec(4, 8, 8, 4,  2'd2, 6'h3F, 2'b10, 2'b00);
        vecs[3] = mkvec(8, 4, 4, 8,  2'd0, 6'h01, 2'b10, 2'b00);
        vecs[4] = mkvec(4, 4, 8, 16, 2'd1, 6'h20, 2'b01, 2'b00);
        vecs[5] = mkvec(4, 8, 4, 4,  2'd0, 6'h0F, 2'b01, 2'b10);

        repeat (3) @(negedge clk);
        chk("reset main", 32'(snap_m()), 32'h0);
        chk("reset sat", 32'(snap_s()), 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            for (int j = 0; j < NR; j++) per_m[j] = int'(vecs[i].per[j]);
            run_meas($sformatf("vec%0d", i), int'(vecs[i].chal), vecs[i].cfg,
                     vecs[i].exp_resp, vecs[i].exp_tie, 1'b0);
        end

        // Abort in the counting phase of pair 1, with a non-zero previous result held
        per_m = '{4, 8, 8, 4};
        @(negedge clk);
        challenge = 2'd0;
        cfg       = 6'h33;
        start     = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        e = {1'b0, 1'b1, pair_mask(0, 1), last_resp, last_tie, 6'h33};
        chk("pre-abort", 32'(snap_m()), 32'(e));
        #2 reset = 1'b0;
        #1 chk("abort immediate", 32'(snap_m()), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort hold %0d", k), 32'(snap_m()), 32'h0);
        end
        reset = 1'b1;
        last_resp = '0;
        last_tie  = '0;
        last_cfg  = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("post-abort idle %0d", k), 32'(snap_m()), 32'h0);
        end
        run_meas("fresh+repulse", 0, 6'h33, 2'b01, 2'b00, 1'b1);

        // 4-bit counters: pair (0,1) both saturate -> tie; pair (2,3) saturated 15 beats 8
        @(negedge clk);
        challenge = 2'd0;
        cfg       = 6'h0C;
        start_s   = 1'b1;
        vk = -1;
        for (int k = 1; k <= LAT + 10 && vk < 0; k++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (valid_s) vk = k;
        end
        chk("sat valid latency", 32'(vk), 32'(LAT));
        chk("sat response", 32'(response_s), 32'(2'b10));
        chk("sat tie", 32'(tie_s), 32'(2'b01));
        @(negedge clk);
        chk("sat idle after", 32'({valid_s, busy_s, ro_enable_s}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
